// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch/decode stage.
// Holds the PC, fetches words over a req/ack handshake, latches them into an
// instruction register and exposes the MIPS-style field slices.
// Optional feature macro: IFD_TIMEOUT_EN adds a fetch watchdog that raises a
// sticky fetch_err and re-issues a fetch that sees no ack for TIMEOUT cycles.
module instr_fetch_decode #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
`ifdef IFD_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc;
  logic        unused_tgt_lsb;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign unused_tgt_lsb = ^branch_target[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: a branch in any active state restarts the fetch at the target.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = FETCH;
      FETCH:   if (branch_en) state_n = FETCH;
               else if (imem_ack) state_n = HOLD;
      HOLD:    if (branch_en || !stall) state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign valid     = (state == HOLD);
  assign imem_addr = pc;

  // PC update and instruction capture; a word acked alongside a branch is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= PC_RESET;
      instr  <= 32'h0;
      pc_out <= 32'h0;
    end else begin
      if (state != IDLE && branch_en)
        pc <= {branch_target[31:2], 2'b00};
      else if (state == HOLD && !stall)
        pc <= pc + 32'd4;
      if (state == FETCH && imem_ack && !branch_en) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
    end
  end

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign jaddr  = instr[25:0];

`ifdef IFD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             err;

  // Watchdog: counts consecutive unacked FETCH cycles; expiry flags and re-arms.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else if (state != FETCH || branch_en || imem_ack) begin
      wd_cnt <= '0;
    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
      wd_cnt <= '0;
      err    <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign fetch_err = err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Testbench for instr_fetch_decode: directed stimulus, a behavioural model
// checked every cycle, and literal expectations for the key scenarios.
module tb_instr_fetch_decode;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        valid;
  logic [31:0] instr, pc_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall),
    .branch_en(branch_en), .branch_target(branch_target), .valid(valid),
    .instr(instr), .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16), .jaddr(jaddr),
    .fetch_err(fetch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "fetching" / "holding a result" flags plus the PC.
  logic        m_known = 1'b0;
  logic        m_idle = 1'b0, m_req = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pcout = 32'h0;
  int          m_wait = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known <= 1'b1; m_idle <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0;
      m_pc <= PC_RESET; m_instr <= 32'h0; m_pcout <= 32'h0; m_err <= 1'b0; m_wait <= 0;
    end else if (m_known) begin
      if (m_idle) begin
        m_idle <= 1'b0; m_req <= 1'b1; m_wait <= 0;
      end else if (branch_en) begin
        m_pc <= branch_target & 32'hFFFF_FFFC; m_req <= 1'b1; m_valid <= 1'b0; m_wait <= 0;
      end else if (m_req && imem_ack) begin
        m_instr <= imem_rdata; m_pcout <= m_pc; m_req <= 1'b0; m_valid <= 1'b1;
      end else if (m_req) begin
`ifdef IFD_TIMEOUT_EN
        if (m_wait + 1 == TIMEOUT) begin
          m_err <= 1'b1; m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
`endif
      end else if (m_valid && !stall) begin
        m_pc <= m_pc + 32'd4; m_valid <= 1'b0; m_req <= 1'b1; m_wait <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("m_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'b0, valid}, {31'b0, m_valid});
      chk("m_instr", instr, m_instr);
      chk("m_pc_out", pc_out, m_pcout);
      chk("m_opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
      chk("m_rs", {27'b0, rs}, {27'b0, m_instr[25:21]});
      chk("m_rt", {27'b0, rt}, {27'b0, m_instr[20:16]});
      chk("m_rd", {27'b0, rd}, {27'b0, m_instr[15:11]});
      chk("m_shamt", {27'b0, shamt}, {27'b0, m_instr[10:6]});
      chk("m_funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
      chk("m_imm16", {16'b0, imm16}, {16'b0, m_instr[15:0]});
      chk("m_jaddr", {6'b0, jaddr}, {6'b0, m_instr[25:0]});
      chk("m_fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    end
  end

  task automatic wait_req(output int n);
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      checks++; failures++;
      $display("FAIL wait_req timeout actual=0 required=1 t=%0t", $time);
    end
  endtask

  task automatic give_ack(input int dly, input logic [31:0] data,
                          output logic [31:0] addr, output int n);
    wait_req(n);
    repeat (dly) @(negedge clk);
    addr = imem_addr;
    imem_ack = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] a;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // Reset then fetch, ack two cycles after request.
    give_ack(2, 32'h2008_FFFF, a, n);
    chk("t1_addr", a, 32'h0);
    chk("t1_valid", {31'b0, valid}, 32'h1);
    chk("t1_opcode", {26'b0, opcode}, 32'h08);
    chk("t1_rs", {27'b0, rs}, 32'h0);
    chk("t1_rt", {27'b0, rt}, 32'h8);
    chk("t1_imm16", {16'b0, imm16}, 32'hFFFF);
    chk("t1_pc_out", pc_out, 32'h0);
    chk("t1_model_instr", m_instr, 32'h2008_FFFF);

    // Sequential zero-wait stream from reset.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    give_ack(0, 32'h014B_4820, a, n);
    chk("t2_addr0", a, 32'h0);
    give_ack(0, 32'h8D09_0004, a, n);
    chk("t2_addr1", a, 32'h4);
    chk("t2_gap1", n, 1);
    give_ack(0, 32'h0800_0040, a, n);
    chk("t2_addr2", a, 32'h8);
    chk("t2_gap2", n, 1);
    chk("t2_jaddr", {6'b0, jaddr}, 32'h40);

    // Stall for five cycles in HOLD.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid", {31'b0, valid}, 32'h1);
      chk("t3_req", {31'b0, imem_req}, 32'h0);
      chk("t3_instr", instr, 32'h0800_0040);
    end
    stall = 1'b0;
    give_ack(0, 32'h0000_0000, a, n);
    chk("t3_addr", a, 32'hC);
    chk("t3_gap", n, 1);

    // Branch colliding with an ack.
    wait_req(n);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    branch_en = 1'b1; branch_target = 32'h0000_0103;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'h0; branch_en = 1'b0;
    chk("t4_req", {31'b0, imem_req}, 32'h1);
    chk("t4_addr", imem_addr, 32'h0000_0100);
    chk("t4_valid", {31'b0, valid}, 32'h0);
    chk("t4_instr", instr, 32'h0000_0000);

    // Branch during a stalled HOLD overrides the stall.
    give_ack(0, 32'h1234_5678, a, n);
    chk("t4_addr_b", a, 32'h0000_0100);
    stall = 1'b1;
    @(negedge clk);
    branch_en = 1'b1; branch_target = 32'hFFFF_FFFE;
    @(negedge clk);
    branch_en = 1'b0; stall = 1'b0;
    chk("t4_br_req", {31'b0, imem_req}, 32'h1);
    chk("t4_br_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t4_br_valid", {31'b0, valid}, 32'h0);

    // PC wrap.
    give_ack(0, 32'hAAAA_5555, a, n);
    chk("t5_addr_top", a, 32'hFFFF_FFFC);
    chk("t5_pc_out", pc_out, 32'hFFFF_FFFC);
    give_ack(0, 32'h5555_AAAA, a, n);
    chk("t5_wrap", a, 32'h0);

    // Reset mid-fetch with a late ack in IDLE.
    wait_req(n);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("t5_rst_req", {31'b0, imem_req}, 32'h1);
    chk("t5_rst_addr", imem_addr, PC_RESET);
    chk("t5_rst_valid", {31'b0, valid}, 32'h0);
    chk("t5_rst_instr", instr, 32'h0);
    give_ack(0, 32'h2402_0001, a, n);
    chk("t5_rst_fetch", a, PC_RESET);
    chk("t5_rst_data", instr, 32'h2402_0001);

`ifdef IFD_TIMEOUT_EN
    // Watchdog: no ack for TIMEOUT cycles.
    wait_req(n);
    a = imem_addr;
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("t6_err_before", {31'b0, fetch_err}, 32'h0);
    @(negedge clk);
    chk("t6_err", {31'b0, fetch_err}, 32'h1);
    chk("t6_req", {31'b0, imem_req}, 32'h1);
    chk("t6_addr", imem_addr, a);
    repeat (5) @(negedge clk);
    give_ack(0, 32'h3C01_1234, a, n);
    chk("t6_late_addr", a, 32'h4);
    chk("t6_valid", {31'b0, valid}, 32'h1);
    chk("t6_instr", instr, 32'h3C01_1234);
    chk("t6_err_sticky", {31'b0, fetch_err}, 32'h1);
`else
    // Without the watchdog a long wait just keeps requesting.
    wait_req(n);
    repeat (TIMEOUT + 5) @(negedge clk);
    chk("t6_no_err", {31'b0, fetch_err}, 32'h0);
    chk("t6_still_req", {31'b0, imem_req}, 32'h1);
    give_ack(0, 32'h3C01_1234, a, n);
    chk("t6_late_addr", a, 32'h4);
    chk("t6_instr", instr, 32'h3C01_1234);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
